// File: rtl/alu_accumulator_stage.sv
// Accumulator/sequencing stage around external combinational bitwise units.
// One command at a time: IDLE accepts, EXEC captures the selected result, DONE holds it.
module alu_accumulator_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_operand,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] opnd_out,
  input  logic [WIDTH-1:0] res_and,
  input  logic [WIDTH-1:0] res_or,
  input  logic [WIDTH-1:0] res_xor,
  input  logic [WIDTH-1:0] res_xnor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             par_flag,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  typedef enum logic [2:0] {
    OpNop  = 3'b000,
    OpLoad = 3'b001,
    OpAnd  = 3'b010,
    OpOr   = 3'b011,
    OpXor  = 3'b100,
    OpXnor = 3'b101,
    OpNot  = 3'b110,
    OpClr  = 3'b111
  } op_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_sel;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             par_q, par_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Result selection; the external units see acc_q/opnd_q held stable through EXEC.
  always_comb begin
    acc_sel = acc_q;
    case (op_e'(op_q))
      OpNop:   acc_sel = acc_q;
      OpLoad:  acc_sel = opnd_q;
      OpAnd:   acc_sel = res_and;
      OpOr:    acc_sel = res_or;
      OpXor:   acc_sel = res_xor;
      OpXnor:  acc_sel = res_xnor;
      OpNot:   acc_sel = ~acc_q;
      OpClr:   acc_sel = '0;
      default: acc_sel = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    par_d   = par_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = in_op;
          opnd_d  = in_operand;
          state_d = StExec;
        end
      end
      StExec: begin
        acc_d   = acc_sel;
        zero_d  = (acc_sel == '0);
        neg_d   = acc_sel[WIDTH-1];
        par_d   = ^acc_sel;
        cnt_d   = cnt_q + CNT_W'(1);
        valid_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 3'b000;
      opnd_q  <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign acc_out   = acc_q;
  assign opnd_out  = opnd_q;
  assign out_valid = valid_q;
  assign zero_flag = zero_q;
  assign neg_flag  = neg_q;
  assign par_flag  = par_q;
  assign op_count  = cnt_q;

endmodule
